tt_um_jleugeri_ttt_token_buffer: RTL and testbench
==================================================

Name: tt_um_jleugeri_ttt_token_buffer

Overview:
Per-processor input token accumulator that sits directly upstream of the processor core. During the INPUT and RECURRENT stages it sums signed good/bad token increments per target processor. Increments come from external inputs and from the network's target_id/new_*_tokens outputs. In the UPDATE stage it streams each processor's accumulated pair, in id order, into the core's new_good_tokens/new_bad_tokens. Each entry is cleared as it is read.

Parameters:
NUM_PROCESSORS, 10, number of buffer entries (one per processor)
NEW_TOKENS_BITS, 4, signed width of each increment and each accumulated value
ID_BITS, $clog2(NUM_PROCESSORS), width of processor id fields

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  single-cycle request: zero all entries
acc_valid  in  1  accumulate request
acc_ready  out  1  accumulate accepted this cycle when acc_valid && acc_ready
acc_id  in  ID_BITS  target processor id
acc_good  in  NEW_TOKENS_BITS  signed good-token increment
acc_bad  in  NEW_TOKENS_BITS  signed bad-token increment
drain_start  in  1  single-cycle request: begin streaming all entries
out_valid  out  1  out_id/out_good/out_bad valid
out_ready  in  1  consumer accepts current entry
out_id  out  ID_BITS  processor id of current entry
out_good  out  NEW_TOKENS_BITS  accumulated good tokens
out_bad  out  NEW_TOKENS_BITS  accumulated bad tokens
done  out  1  one-cycle pulse after last entry accepted
busy  out  1  high while in DRAIN or DONE
id_err  out  1  sticky: an out-of-range acc_id was offered
sat_flag  out  1  sticky: an accumulation saturated (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous):
  - all entries = 0; state = IDLE; drain index = 0.
  - out_valid, done, busy, id_err, sat_flag = 0.
  - acc_ready = 0 while reset is held.
  - out_id, out_good and out_bad reset to 0.
- States: IDLE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - acc_ready = !clear && !drain_start (combinational).
  - clear: all entries zeroed on the next edge; id_err and sat_flag are also cleared.
  - Accepted accumulate with acc_id < NUM_PROCESSORS: entry[acc_id].good += acc_good and entry[acc_id].bad += acc_bad on the same edge. The result is visible to the next accumulate, giving one per cycle with back-to-back same-id supported.
  - acc_id >= NUM_PROCESSORS: the request is still accepted (handshake completes), but no entry changes and id_err is set.
  - drain_start (clear low): go to DRAIN with index 0.
  - clear and drain_start in the same cycle: clear wins and drain_start is ignored.
- DRAIN:
  - out_valid = 1; out_id = index; out_good/out_bad = entry[index] (combinational from the registers).
  - On out_valid && out_ready: entry[index] is zeroed and index increments.
  - If index == NUM_PROCESSORS-1 on that handshake, go to DONE.
  - out_ready low: outputs hold stable and the entry is untouched.
  - acc_ready = 0. clear and drain_start are ignored.
- DONE: done = 1 for exactly one cycle; out_valid = 0; index resets to 0; return to IDLE.
- Latency: drain_start to first out_valid is 1 cycle. With out_ready held high, the last handshake to done is 1 cycle, so a full drain is NUM_PROCESSORS+1 cycles after drain_start.
- Arithmetic: two's complement, NEW_TOKENS_BITS wide. The sum is computed at NEW_TOKENS_BITS+1 bits, then saturated or wrapped per the feature macro.
- reset_n asserted mid-DRAIN: immediate return to IDLE with all entries zeroed; no done pulse.

Optional Feature:
- Macro: TTT_TOKEN_BUFFER_SAT_EN.
- Defined: results are clamped to [-2^(NEW_TOKENS_BITS-1), 2^(NEW_TOKENS_BITS-1)-1]. Any clamp on either the good or the bad sum sets sat_flag.
- Undefined: results wrap modulo 2^NEW_TOKENS_BITS, and sat_flag is tied to 0.

Test Plan:
- Reset, then drain_start with out_ready=1: out_id steps 0..9 with out_good=out_bad=0 on every entry; done pulses on cycle 11 after drain_start; busy low afterwards.
- Accumulate id3 (+2,-1), id3 (+3,+4), id7 (-5,0) back-to-back, then drain: entry 3 = (5,3), entry 7 = (-5,0), all others 0. A second drain returns all zeros (read-clear).
- SAT_EN defined: id0 +7 then +1 -> out_good=7 and sat_flag=1. Undefined: out_good=-8 and sat_flag=0. Also id1 -8 then -1 -> -8 (sat) / 7 (wrap).
- Drain with out_ready low for 3 cycles at index 4: out_id=4 with values stable; acc_valid during drain sees acc_ready=0 and is not applied.
- acc_id=12: handshake completes, id_err=1, no entry changes. A following clear zeroes id_err. clear and drain_start in the same cycle -> entries zeroed and state stays IDLE.
- Assert reset_n low at index 5 mid-drain: out_valid=0 immediately, no done pulse, and a subsequent drain reads all zeros.

Source files
------------

// File: rtl/tt_um_jleugeri_ttt_token_buffer.sv
// Per-processor signed good/bad token accumulator, drained in id order into the processor core.
// Define TTT_TOKEN_BUFFER_SAT_EN to saturate sums (and report via sat_flag); otherwise sums wrap.
module tt_um_jleugeri_ttt_token_buffer #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NEW_TOKENS_BITS = 4,
  parameter int ID_BITS         = $clog2(NUM_PROCESSORS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  input  logic [ID_BITS-1:0]         acc_id,
  input  logic [NEW_TOKENS_BITS-1:0] acc_good,
  input  logic [NEW_TOKENS_BITS-1:0] acc_bad,
  input  logic                       drain_start,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ID_BITS-1:0]         out_id,
  output logic [NEW_TOKENS_BITS-1:0] out_good,
  output logic [NEW_TOKENS_BITS-1:0] out_bad,
  output logic                       done,
  output logic                       busy,
  output logic                       id_err,
  output logic                       sat_flag
);

  localparam int W = NEW_TOKENS_BITS;
  localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_PROCESSORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [ID_BITS-1:0]    r_idx;
  logic signed [W-1:0]   r_good [NUM_PROCESSORS];
  logic signed [W-1:0]   r_bad  [NUM_PROCESSORS];
  logic                  r_id_err;

  logic                  w_id_ok;
  logic                  w_accept;
  logic signed [W-1:0]   w_cur_good;
  logic signed [W-1:0]   w_cur_bad;
  logic signed [W-1:0]   w_good_res;
  logic signed [W-1:0]   w_bad_res;

`ifdef TTT_TOKEN_BUFFER_SAT_EN
  // Sum one bit wider than the operands; a sign mismatch in the top two bits means overflow.
  function automatic logic signed [W-1:0] f_sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b,
                                                    output logic ovf);
    logic signed [W:0] wide;
    wide = {a[W-1], a} + {b[W-1], b};
    ovf  = wide[W] ^ wide[W-1];
    if (!ovf)         return wide[W-1:0];
    else if (wide[W]) return {1'b1, {(W-1){1'b0}}};
    else              return {1'b0, {(W-1){1'b1}}};
  endfunction

  logic w_good_ovf;
  logic w_bad_ovf;
  logic r_sat;

  always_comb begin
    w_good_res = f_sat_add(w_cur_good, acc_good, w_good_ovf);
    w_bad_res  = f_sat_add(w_cur_bad,  acc_bad,  w_bad_ovf);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sat <= 1'b0;
    else if (r_state == S_IDLE && clear)
      r_sat <= 1'b0;
    else if (w_accept && w_id_ok && (w_good_ovf || w_bad_ovf))
      r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  // Modulo-2^W addition: identical to the low bits of the widened sum.
  function automatic logic signed [W-1:0] f_wrap_add(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b);
    return a + b;
  endfunction

  assign w_good_res = f_wrap_add(w_cur_good, acc_good);
  assign w_bad_res  = f_wrap_add(w_cur_bad,  acc_bad);
  assign sat_flag   = 1'b0;
`endif

  assign w_id_ok    = int'(acc_id) < NUM_PROCESSORS;
  assign w_cur_good = w_id_ok ? r_good[acc_id] : '0;
  assign w_cur_bad  = w_id_ok ? r_bad[acc_id]  : '0;

  assign acc_ready  = reset_n && (r_state == S_IDLE) && !clear && !drain_start;
  assign w_accept   = acc_valid && acc_ready;

  assign out_valid  = (r_state == S_DRAIN);
  assign out_id     = out_valid ? r_idx : '0;
  assign out_good   = out_valid ? r_good[r_idx] : '0;
  assign out_bad    = out_valid ? r_bad[r_idx]  : '0;
  assign done       = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign id_err     = r_id_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_id_err <= 1'b0;
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        r_good[i] <= '0;
        r_bad[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_id_err <= 1'b0;
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
              r_good[i] <= '0;
              r_bad[i]  <= '0;
            end
          end else if (drain_start) begin
            r_state <= S_DRAIN;
            r_idx   <= '0;
          end else if (w_accept) begin
            // Out-of-range ids still complete the handshake but only raise the error flag.
            if (w_id_ok) begin
              r_good[acc_id] <= w_good_res;
              r_bad[acc_id]  <= w_bad_res;
            end else begin
              r_id_err <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            r_good[r_idx] <= '0;
            r_bad[r_idx]  <= '0;
            if (r_idx == LAST_ID) begin
              r_state <= S_DONE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + ID_BITS'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_token_buffer.sv
// Bench for the token buffer: vector table, directed drain corner cases, and random accumulation
// against an integer reference model.
module tb_tt_um_jleugeri_ttt_token_buffer;

  localparam int N   = 10;
  localparam int W   = 4;
  localparam int IDB = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           clear = 1'b0;
  logic           acc_valid = 1'b0;
  logic           acc_ready;
  logic [IDB-1:0] acc_id = '0;
  logic [W-1:0]   acc_good = '0;
  logic [W-1:0]   acc_bad = '0;
  logic           drain_start = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [IDB-1:0] out_id;
  logic [W-1:0]   out_good;
  logic [W-1:0]   out_bad;
  logic           done;
  logic           busy;
  logic           id_err;
  logic           sat_flag;

  tt_um_jleugeri_ttt_token_buffer #(
    .NUM_PROCESSORS(N), .NEW_TOKENS_BITS(W), .ID_BITS(IDB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_id(acc_id), .acc_good(acc_good), .acc_bad(acc_bad), .drain_start(drain_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_good(out_good),
    .out_bad(out_bad), .done(done), .busy(busy), .id_err(id_err), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mg[N];
  int mb[N];
  bit m_err = 1'b0;
  bit m_sat = 1'b0;

  typedef struct {
    int id; int g; int b;
    int eg; int eb; bit eerr; bit esat;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic on plain integers.
  function automatic int resolve(int v, output bit s);
    s = (v > 7) || (v < -8);
`ifdef TTT_TOKEN_BUFFER_SAT_EN
    if (v > 7) return 7;
    if (v < -8) return -8;
    return v;
`else
    return ((v + 8) % 16 + 16) % 16 - 8;
`endif
  endfunction

  function automatic int sx(logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      mg[i] = 0;
      mb[i] = 0;
    end
  endtask

  task automatic acc(int id, int g, int b);
    bit sg, sb;
    acc_valid = 1'b1;
    acc_id    = IDB'(id);
    acc_good  = W'(g);
    acc_bad   = W'(b);
    #1;
    chk("acc_ready_idle", int'(acc_ready), 1);
    step();
    acc_valid = 1'b0;
    if (id < N) begin
      mg[id] = resolve(mg[id] + g, sg);
      mb[id] = resolve(mb[id] + b, sb);
`ifdef TTT_TOKEN_BUFFER_SAT_EN
      m_sat = m_sat | sg | sb;
`endif
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Full drain; optionally stall at one index or assert reset at one index.
  task automatic drain(int stall_at, int reset_at);
    drain_start = 1'b1;
    #1;
    chk("acc_ready_on_drain_start", int'(acc_ready), 0);
    step();
    drain_start = 1'b0;
    out_ready   = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == reset_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_busy", int'(busy), 0);
        model_zero();
        m_err = 1'b0;
        m_sat = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          step();
          chk("rst_mid_no_done", int'(done), 0);
        end
        out_ready = 1'b0;
        return;
      end
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_id", int'(out_id), i);
      chk("drain_good", sx(out_good), mg[i]);
      chk("drain_bad", sx(out_bad), mb[i]);
      chk("drain_busy", int'(busy), 1);
      if (i == stall_at) begin
        out_ready = 1'b0;
        acc_valid = 1'b1;
        acc_id    = IDB'(i);
        acc_good  = W'(1);
        acc_bad   = W'(1);
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_acc_ready", int'(acc_ready), 0);
          step();
          chk("stall_id", int'(out_id), i);
          chk("stall_good", sx(out_good), mg[i]);
          chk("stall_bad", sx(out_bad), mb[i]);
          chk("stall_valid", int'(out_valid), 1);
        end
        acc_valid = 1'b0;
        out_ready = 1'b1;
      end
      step();
      mg[i] = 0;
      mb[i] = 0;
    end
    chk("done_pulse", int'(done), 1);
    chk("done_out_valid", int'(out_valid), 0);
    chk("done_busy", int'(busy), 1);
    out_ready = 1'b0;
    step();
    chk("done_cleared", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    bit s;
    model_zero();

    // Vector table: accumulate, then the entry value expected after that row.
    tbl[0] = '{3,  2, -1,  2, -1, 1'b0, 1'b0};
    tbl[1] = '{3,  3,  4,  5,  3, 1'b0, 1'b0};
    tbl[2] = '{7, -5,  0, -5,  0, 1'b0, 1'b0};
    tbl[3] = '{0,  7,  0,  7,  0, 1'b0, 1'b0};
`ifdef TTT_TOKEN_BUFFER_SAT_EN
    tbl[4] = '{0,  1,  0,  7,  0, 1'b0, 1'b1};
    tbl[5] = '{1, -8,  0, -8,  0, 1'b0, 1'b1};
    tbl[6] = '{1, -1,  0, -8,  0, 1'b0, 1'b1};
    tbl[7] = '{12, 1,  1,  0,  0, 1'b1, 1'b1};
`else
    tbl[4] = '{0,  1,  0, -8,  0, 1'b0, 1'b0};
    tbl[5] = '{1, -8,  0, -8,  0, 1'b0, 1'b0};
    tbl[6] = '{1, -1,  0,  7,  0, 1'b0, 1'b0};
    tbl[7] = '{12, 1,  1,  0,  0, 1'b1, 1'b0};
`endif

    // Reset state
    #3;
    chk("rst_acc_ready", int'(acc_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id_err", int'(id_err), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_good", sx(out_good), 0);
    chk("rst_out_bad", sx(out_bad), 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    drain(-1, -1);

    for (int i = 0; i < 8; i++) begin
      acc(tbl[i].id, tbl[i].g, tbl[i].b);
      chk("tbl_id_err", int'(id_err), int'(tbl[i].eerr));
      chk("tbl_sat", int'(sat_flag), int'(tbl[i].esat));
    end
    // Table values become the drain expectations for the touched entries.
    model_zero();
    for (int i = 0; i < 8; i++)
      if (tbl[i].id < N) begin
        mg[tbl[i].id] = tbl[i].eg;
        mb[tbl[i].id] = tbl[i].eb;
      end
    drain(-1, -1);
    drain(-1, -1);

    // Stall at index 4 with accumulate attempts during drain
    acc(4, 3, -2);
    acc(5, -4, 6);
    drain(4, -1);
    drain(-1, -1);

    // id_err then clear; clear wins over drain_start
    acc(12, 1, 1);
    chk("id_err_set", int'(id_err), 1);
    acc(2, 3, 3);
    clear = 1'b1;
    #1;
    chk("acc_ready_clear", int'(acc_ready), 0);
    step();
    clear = 1'b0;
    model_zero();
    m_err = 1'b0;
    m_sat = 1'b0;
    chk("clear_id_err", int'(id_err), 0);
    chk("clear_sat", int'(sat_flag), 0);
    acc(6, 2, 2);
    clear = 1'b1;
    drain_start = 1'b1;
    step();
    clear = 1'b0;
    drain_start = 1'b0;
    model_zero();
    chk("clr_drn_busy", int'(busy), 0);
    chk("clr_drn_out_valid", int'(out_valid), 0);
    step();
    chk("clr_drn_busy2", int'(busy), 0);
    drain(-1, -1);

    // Reset mid-drain at index 5
    acc(5, 1, 1);
    acc(8, -3, 2);
    drain(-1, 5);
    chk("post_rst_busy", int'(busy), 0);
    drain(-1, -1);

    // Randomized accumulation against the model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
      end else begin
        acc(int'($urandom_range(0, 11)), int'($urandom_range(0, 15)) - 8,
            int'($urandom_range(0, 15)) - 8);
        chk("rnd_id_err", int'(id_err), int'(m_err));
        chk("rnd_sat", int'(sat_flag), int'(m_sat));
      end
    end
    drain(-1, -1);
    s = 1'b0;
    chk("final_sat", int'(sat_flag), int'(m_sat | s));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
